// File: rtl/ones_arb_pkg.sv
// Shared types and default sizing for the round-robin ones-count arbiter.
// Optional threshold output is enabled in the top by defining ONES_THRESH_EN.
package ones_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_CNT_W   = 5;

endpackage

// File: rtl/ones_count_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        sum;

  // Rotate so ptr sits at bit 0; the lowest set bit is then the distance to the winner.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_REQ-1:0];
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ID_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    winner = sum[ID_W-1:0];
    grant  = '0;
    if (|req) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/ones_count_arbiter.sv
// Round-robin front end sharing one bit-serial ones-counter between NUM_REQ sources.
// Define ONES_THRESH_EN to add the thresh input and the registered z output.
module ones_count_arbiter
  import ones_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            ones_out,
  output logic [$clog2(NUM_REQ)-1:0]  out_id
`ifdef ONES_THRESH_EN
  ,
  input  logic [CNT_W-1:0]            thresh,
  output logic                        z
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(DATA_W + 1);

  state_t              state, next_state;
  logic [ID_W-1:0]     ptr, next_ptr, winner;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   shift_reg, sel_word;
  logic [BC_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]    acc, sum_next;
  logic                capture, finish, release_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign sum_next = acc + CNT_W'(shift_reg[0]);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    capture      = 1'b0;
    finish       = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          capture    = 1'b1;
          next_state = COUNT;
        end
      end
      COUNT: begin
        if (bit_cnt == BC_W'(1)) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_done = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture on grant, one bit per COUNT edge, result held until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      ones_out  <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
    end else begin
      gnt <= '0;
      if (capture) begin
        shift_reg <= sel_word;
        acc       <= '0;
        bit_cnt   <= BC_W'(DATA_W);
        out_id    <= winner;
        gnt       <= grant;
        ptr       <= next_ptr;
      end
      if (state == COUNT) begin
        acc       <= sum_next;
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt - BC_W'(1);
      end
      if (finish) begin
        ones_out  <= sum_next;
        out_valid <= 1'b1;
      end
      if (release_done) out_valid <= 1'b0;
    end
  end

`ifdef ONES_THRESH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               z <= 1'b0;
    else if (finish)       z <= (sum_next >= thresh);
    else if (release_done) z <= 1'b0;
  end
`endif

endmodule
